// File: rtl/alu_operand_stage.sv
// ALU operand stage for the pipelined RV32IM core.
// It selects Op1 and Op2 from the decoded sources and forwards EX/MEM and MEM/WB
// results into them. It holds decode back when a load-use hazard is present.
// It registers the operands, the store data and the sideband into one ID/EX slot.
// That slot uses a valid/ready handshake and can be flushed.
module alu_operand_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned SB_WIDTH = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_AW-1:0]   rs1_addr,
    input  logic [REG_AW-1:0]   rs2_addr,
    input  logic [WIDTH-1:0]    rs1_data,
    input  logic [WIDTH-1:0]    rs2_data,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [WIDTH-1:0]    imm,
    input  logic [1:0]          op1_sel,
    input  logic [1:0]          op2_sel,
    input  logic                rs2_needed,
    input  logic [SB_WIDTH-1:0] sb_in,

    input  logic                fwd_ex_valid,
    input  logic [REG_AW-1:0]   fwd_ex_rd,
    input  logic [WIDTH-1:0]    fwd_ex_data,
    input  logic                fwd_ex_load,
    input  logic                fwd_wb_valid,
    input  logic [REG_AW-1:0]   fwd_wb_rd,
    input  logic [WIDTH-1:0]    fwd_wb_data,

    input  logic                flush,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    op1,
    output logic [WIDTH-1:0]    op2,
    output logic [WIDTH-1:0]    store_data,
    output logic [SB_WIDTH-1:0] sb_out,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [1:0] OP1_RS1  = 2'b00;
    localparam logic [1:0] OP1_PC   = 2'b01;
    localparam logic [1:0] OP1_ZERO = 2'b10;

    localparam logic [1:0] OP2_RS2  = 2'b00;
    localparam logic [1:0] OP2_IMM  = 2'b01;
    localparam logic [1:0] OP2_FOUR = 2'b10;

    localparam logic [WIDTH-1:0] LINK_OFFSET = WIDTH'(4);

    // Slot registers.
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    op1_q, op1_d;
    logic [WIDTH-1:0]    op2_q, op2_d;
    logic [WIDTH-1:0]    sdata_q, sdata_d;
    logic [SB_WIDTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Combinational datapath and handshake signals.
    logic             use1_c;
    logic             use2_c;
    logic             ex_hit1_c, ex_hit2_c;
    logic             wb_hit1_c, wb_hit2_c;
    logic             ld_hit1_c, ld_hit2_c;
    logic [WIDTH-1:0] rs1_fwd_c;
    logic [WIDTH-1:0] rs2_fwd_c;
    logic [WIDTH-1:0] op1_c;
    logic [WIDTH-1:0] op2_c;
    logic             hz_c;
    logic             xfer_c;

    // A source counts as consumed only when its value feeds the operands or the store data.
    always_comb begin
        use1_c = (op1_sel == OP1_RS1);
        use2_c = (op2_sel == OP2_RS2) | rs2_needed;
    end

    // Match each source against EX and WB. An EX load has no data yet, so it is never forwarded.
    always_comb begin
        ex_hit1_c = fwd_ex_valid & ~fwd_ex_load & (fwd_ex_rd == rs1_addr) & (rs1_addr != '0);
        ex_hit2_c = fwd_ex_valid & ~fwd_ex_load & (fwd_ex_rd == rs2_addr) & (rs2_addr != '0);
        wb_hit1_c = fwd_wb_valid & (fwd_wb_rd == rs1_addr) & (rs1_addr != '0);
        wb_hit2_c = fwd_wb_valid & (fwd_wb_rd == rs2_addr) & (rs2_addr != '0);
        ld_hit1_c = use1_c & (fwd_ex_rd == rs1_addr);
        ld_hit2_c = use2_c & (fwd_ex_rd == rs2_addr);
    end

    // Pick each source value. x0 reads zero, then EX wins over WB, then the register file.
    always_comb begin
        rs1_fwd_c = rs1_data;
        if (rs1_addr == '0) begin
            rs1_fwd_c = '0;
        end else if (ex_hit1_c) begin
            rs1_fwd_c = fwd_ex_data;
        end else if (wb_hit1_c) begin
            rs1_fwd_c = fwd_wb_data;
        end

        rs2_fwd_c = rs2_data;
        if (rs2_addr == '0) begin
            rs2_fwd_c = '0;
        end else if (ex_hit2_c) begin
            rs2_fwd_c = fwd_ex_data;
        end else if (wb_hit2_c) begin
            rs2_fwd_c = fwd_wb_data;
        end
    end

    // Operand muxes. The PC is zero-extended, and the reserved encodings give zero.
    always_comb begin
        op1_c = '0;
        unique case (op1_sel)
            OP1_RS1:  op1_c = rs1_fwd_c;
            OP1_PC:   op1_c = WIDTH'(pc);
            OP1_ZERO: op1_c = '0;
            default:  op1_c = '0;
        endcase

        op2_c = '0;
        unique case (op2_sel)
            OP2_RS2:  op2_c = rs2_fwd_c;
            OP2_IMM:  op2_c = imm;
            OP2_FOUR: op2_c = LINK_OFFSET;
            default:  op2_c = '0;
        endcase
    end

    // A load-use hazard holds decode back. The slot drains meanwhile, so no bubble is written.
    always_comb begin
        hz_c     = in_valid & fwd_ex_valid & fwd_ex_load & (fwd_ex_rd != '0)
                 & (ld_hit1_c | ld_hit2_c);
        in_ready = ~hz_c & (~valid_q | out_ready);
        xfer_c   = in_valid & in_ready;
    end

    // Slot update. Flush wins over a transfer and drops it; the data registers keep their contents.
    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sdata_d = sdata_q;
        sb_d    = sb_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer_c) begin
            valid_d = 1'b1;
            op1_d   = op1_c;
            op2_d   = op2_c;
            sdata_d = rs2_fwd_c;
            sb_d    = sb_in;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Load-use stall counter. It saturates at all-ones and only reset clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (hz_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            sdata_q <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sdata_q <= sdata_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs driven straight from the slot registers.
    always_comb begin
        out_valid  = valid_q;
        op1        = op1_q;
        op2        = op2_q;
        store_data = sdata_q;
        sb_out     = sb_q;
        stall_cnt  = cnt_q;
    end

endmodule
